xadc_drp_responder: RTL and testbench

DRP responder that stands in for the XADC/System Monitor primitive on boards or sim builds without one. It serves the same DRP read/write handshake a DRP initiator issues (DEN, DWE, DADDR, DI, DO, DRDY). It also runs a free-running conversion sequencer producing BUSY/EOC/EOS and updating the temperature status register from an externally supplied 12-bit code. It sits behind the temperature-sensor readout logic as a drop-in replacement for the hard XADC.

---
 rtl/xadc_drp_responder_pkg.sv | 29 ++
 rtl/xadc_conv_sequencer.sv | 78 +++++++
 rtl/xadc_drp_responder.sv | 164 ++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_responder_pkg.sv
// ============================================================================
// xadc_drp_responder_pkg : register map and state encodings shared by the
//                          XADC stand-in DRP responder and its sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xadc_drp_responder_pkg;

    localparam logic [6:0] ADDR_TEMP = 7'h00;
    localparam logic [6:0] ADDR_MAXT = 7'h20;
    localparam logic [6:0] ADDR_MINT = 7'h24;
    localparam logic [6:0] ADDR_FLAG = 7'h3F;
    localparam logic [6:0] ADDR_CFG0 = 7'h40;
    localparam logic [6:0] ADDR_CFG1 = 7'h41;
    localparam logic [6:0] ADDR_CFG2 = 7'h42;

    localparam logic [0:0] DRP_IDLE = 1'b0;
    localparam logic [0:0] DRP_PEND = 1'b1;

    localparam logic [0:0] SEQ_GAP  = 1'b0;
    localparam logic [0:0] SEQ_CONV = 1'b1;

    localparam logic [15:0] MINT_RESET = 16'hFFFF;
    localparam logic [15:0] FLAG_VALUE = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/xadc_conv_sequencer.sv
// ============================================================================
// xadc_conv_sequencer : free-running GAP/CONV timeline producing busy/eoc/eos
//                       and a one-cycle register update strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xadc_conv_sequencer
    import xadc_drp_responder_pkg::*;
#(
    parameter int CONV_CYCLES = 26,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] temp_code,
    output logic        busy,
    output logic        eoc,
    output logic        eos,
    output logic        upd,
    output logic [15:0] upd_value
);

    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic [11:0] r_code;
    logic        r_busy;
    logic        r_eoc;

    // The update fires combinationally so the register file commits on the
    // very edge that ends the conversion and raises eoc.
    assign upd       = (r_state == SEQ_CONV) && (r_cnt == CONV_LAST);
    assign upd_value = {r_code, 4'h0};
    assign busy      = r_busy;
    assign eoc       = r_eoc;
    assign eos       = r_eoc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEQ_GAP;
            r_cnt   <= 8'd0;
            r_code  <= 12'h000;
            r_busy  <= 1'b0;
            r_eoc   <= 1'b0;
        end else begin
            r_eoc <= 1'b0;
            case (r_state)
                SEQ_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= SEQ_CONV;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_code  <= temp_code;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                SEQ_CONV: begin
                    if (upd) begin
                        r_state <= SEQ_GAP;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_eoc   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= SEQ_GAP;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/xadc_drp_responder.sv
// ============================================================================
// xadc_drp_responder : DRP register file and handshake FSM emulating the
//                      XADC temperature channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xadc_drp_responder
    import xadc_drp_responder_pkg::*;
#(
    parameter int RD_LATENCY  = 4,
    parameter int CONV_CYCLES = 26,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        den,
    input  logic        dwe,
    input  logic [6:0]  daddr,
    input  logic [15:0] di,
    output logic [15:0] do_out,
    output logic        drdy,
    output logic        busy,
    output logic        eoc,
    output logic        eos,
    output logic [4:0]  channel,
    input  logic [11:0] temp_code,
    output logic        err_overlap
);

    localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [6:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_snap;
    logic [15:0] r_do;
    logic        r_drdy;
    logic        r_err;
    logic [15:0] r_temp;
    logic [15:0] r_maxt;
    logic [15:0] r_mint;
    logic [15:0] r_cfg0;
    logic [15:0] r_cfg1;
    logic [15:0] r_cfg2;

    logic        w_upd;
    logic [15:0] w_upd_value;
    logic [15:0] w_rd_data;
    logic        w_fire;

    xadc_conv_sequencer #(
        .CONV_CYCLES (CONV_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .temp_code (temp_code),
        .busy      (busy),
        .eoc       (eoc),
        .eos       (eos),
        .upd       (w_upd),
        .upd_value (w_upd_value)
    );

    assign channel     = 5'h00;
    assign do_out      = r_do;
    assign drdy        = r_drdy;
    assign err_overlap = r_err;
    assign w_fire      = (r_state == DRP_PEND) && (r_cnt == 4'd0);

    always_comb begin
        w_rd_data = 16'h0000;
        case (daddr)
            ADDR_TEMP: w_rd_data = r_temp;
            ADDR_MAXT: w_rd_data = r_maxt;
            ADDR_MINT: w_rd_data = r_mint;
            ADDR_FLAG: w_rd_data = FLAG_VALUE;
            ADDR_CFG0: w_rd_data = r_cfg0;
            ADDR_CFG1: w_rd_data = r_cfg1;
            ADDR_CFG2: w_rd_data = r_cfg2;
            default:   w_rd_data = 16'h0000;
        endcase
    end

    // Reads are snapshotted at capture, so a same-edge temperature update is
    // not visible to that read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DRP_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 7'h00;
            r_wdata <= 16'h0000;
            r_snap  <= 16'h0000;
            r_do    <= 16'h0000;
            r_drdy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_drdy <= 1'b0;
            r_do   <= 16'h0000;
            r_err  <= 1'b0;
            case (r_state)
                DRP_IDLE: begin
                    if (den) begin
                        r_we    <= dwe;
                        r_addr  <= daddr;
                        r_wdata <= di;
                        r_snap  <= w_rd_data;
                        r_cnt   <= LAT_LAST;
                        r_state <= DRP_PEND;
                    end
                end
                DRP_PEND: begin
                    if (den) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == 4'd0) begin
                        r_drdy  <= 1'b1;
                        r_do    <= r_we ? 16'h0000 : r_snap;
                        r_state <= DRP_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= DRP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_temp <= 16'h0000;
            r_maxt <= 16'h0000;
            r_mint <= MINT_RESET;
            r_cfg0 <= 16'h0000;
            r_cfg1 <= 16'h0000;
            r_cfg2 <= 16'h0000;
        end else begin
            if (w_upd) begin
                r_temp <= w_upd_value;
                if (w_upd_value > r_maxt) begin
                    r_maxt <= w_upd_value;
                end
                if (w_upd_value < r_mint) begin
                    r_mint <= w_upd_value;
                end
            end
            if (w_fire && r_we) begin
                case (r_addr)
                    ADDR_CFG0: r_cfg0 <= r_wdata;
                    ADDR_CFG1: r_cfg1 <= r_wdata;
                    ADDR_CFG2: r_cfg2 <= r_wdata;
                    default:   ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_responder.sv
// ============================================================================
// tb_xadc_drp_responder : scoreboard bench for the XADC stand-in responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xadc_drp_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [6:0]  daddr = 7'h00;
    logic [15:0] di = 16'h0000;
    logic [11:0] temp_code = 12'h977;
    logic [15:0] do_out;
    logic        drdy;
    logic        busy;
    logic        eoc;
    logic        eos;
    logic [4:0]  channel;
    logic        err_overlap;

    typedef struct {
        int          due;
        logic [6:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   err_due[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    xadc_drp_responder #(
        .RD_LATENCY  (4),
        .CONV_CYCLES (26),
        .GAP_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .den         (den),
        .dwe         (dwe),
        .daddr       (daddr),
        .di          (di),
        .do_out      (do_out),
        .drdy        (drdy),
        .busy        (busy),
        .eoc         (eoc),
        .eos         (eos),
        .channel     (channel),
        .temp_code   (temp_code),
        .err_overlap (err_overlap)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; a sample at a falling edge reads the
    // count of rising edges already taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge rst_n) begin
        sb.delete();
        err_due.delete();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Sequencer reference: busy after edges 4..29 of each 30-edge period,
    // eoc/eos after every 30th edge.
    always @(negedge clk) begin : mon
        int   p;
        logic exp_busy;
        logic exp_eoc;
        logic exp_err;
        exp_t e;
        if (rst_n) begin
            p        = cyc % 30;
            exp_busy = (p >= 4);
            exp_eoc  = (cyc > 0) && (p == 0);
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("eoc", {31'd0, eoc}, {31'd0, exp_eoc});
            check("eos", {31'd0, eos}, {31'd0, exp_eoc});
            exp_err = (err_due.size() > 0) && (err_due[0] == cyc);
            if (exp_err) void'(err_due.pop_front());
            check("err_overlap", {31'd0, err_overlap}, {31'd0, exp_err});
            if (drdy) begin
                if (sb.size() == 0) begin
                    check("drdy_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("drdy_cycle", cyc, e.due);
                    check($sformatf("do_out@%02h", e.addr), {16'd0, do_out}, {16'd0, e.data});
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check($sformatf("drdy_timeout@%02h", e.addr), 32'd0, 32'd1);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives one den strobe; an overlapping request expects only err_overlap.
    task automatic issue(input logic we, input logic [6:0] addr, input logic [15:0] data,
                         input logic [15:0] exp, input bit overlap);
        den   = 1'b1;
        dwe   = we;
        daddr = addr;
        di    = data;
        if (overlap) err_due.push_back(cyc + 1);
        else         sb.push_back('{due: cyc + 5, addr: addr, data: exp});
        @(negedge clk);
        den   = 1'b0;
        dwe   = 1'b0;
        di    = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("channel", {27'd0, channel}, 32'd0);
        check("reset_do_out", {16'd0, do_out}, 32'd0);

        issue(1'b0, 7'h00, 16'h0000, 16'h0000, 1'b0);
        wait_until(6);   issue(1'b0, 7'h24, 16'h0000, 16'hFFFF, 1'b0);
        wait_until(12);  issue(1'b0, 7'h20, 16'h0000, 16'h0000, 1'b0);
        wait_until(18);  issue(1'b1, 7'h40, 16'hA5C3, 16'h0000, 1'b0);
        wait_until(24);  issue(1'b0, 7'h40, 16'h0000, 16'hA5C3, 1'b0);
        temp_code = 12'h9A0;
        wait_until(30);  issue(1'b1, 7'h00, 16'h1234, 16'h0000, 1'b0);
        wait_until(36);  issue(1'b0, 7'h00, 16'h0000, 16'h9770, 1'b0);
        temp_code = 12'h950;
        wait_until(42);  issue(1'b0, 7'h55, 16'h0000, 16'h0000, 1'b0);
        wait_until(48);  issue(1'b0, 7'h24, 16'h0000, 16'h9770, 1'b0);
        // Snapshot lands on the same edge as the second conversion update.
        wait_until(59);  issue(1'b0, 7'h00, 16'h0000, 16'h9770, 1'b0);
        wait_until(66);  issue(1'b0, 7'h00, 16'h0000, 16'h9A00, 1'b0);
        wait_until(96);  issue(1'b0, 7'h20, 16'h0000, 16'h9A00, 1'b0);
        wait_until(102); issue(1'b0, 7'h24, 16'h0000, 16'h9500, 1'b0);
        wait_until(108); issue(1'b0, 7'h00, 16'h0000, 16'h9500, 1'b0);
        wait_until(114); issue(1'b0, 7'h3F, 16'h0000, 16'h0000, 1'b0);
        wait_until(116); issue(1'b1, 7'h41, 16'hFFFF, 16'h0000, 1'b1);
        wait_until(124); issue(1'b0, 7'h41, 16'h0000, 16'h0000, 1'b0);

        // Asynchronous reset while a read is pending: that read must vanish.
        wait_until(130); issue(1'b0, 7'h00, 16'h0000, 16'h9500, 1'b0);
        wait_until(132);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cyc", cyc, 32'd0);
        issue(1'b0, 7'h24, 16'h0000, 16'hFFFF, 1'b0);
        wait_until(6);   issue(1'b0, 7'h20, 16'h0000, 16'h0000, 1'b0);
        wait_until(12);  issue(1'b0, 7'h40, 16'h0000, 16'h0000, 1'b0);
        wait_until(18);  issue(1'b0, 7'h00, 16'h0000, 16'h0000, 1'b0);
        wait_until(70);
        check("sb_drained", sb.size(), 32'd0);
        check("err_drained", err_due.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
